// File: rtl/sha3_state_fifo_if.sv
// Port bundle for sha3_state_fifo: incoming state rows, head-of-queue rows and status.
// Row signals are packed [lane][bit]; index = lane within the row.
interface sha3_state_fifo_if #(
  parameter int LANE_W = 64,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [4:0][LANE_W-1:0] isa, isb, isc, isd, ise;
  logic                   ivalid;
  logic                   iready;
  logic [4:0][LANE_W-1:0] osa, osb, osc, osd, ose;
  logic                   ovalid;
  logic                   oready;
  logic [CNT_W-1:0]       count;
  logic                   overflow;

  modport master (
    output isa, isb, isc, isd, ise, ivalid, oready,
    input  iready, osa, osb, osc, osd, ose, ovalid, count, overflow
  );

  modport slave (
    input  isa, isb, isc, isd, ise, ivalid, oready,
    output iready, osa, osb, osc, osd, ose, ovalid, count, overflow
  );
endinterface

// File: rtl/sha3_state_fifo.sv
// DEPTH-slot FIFO of 5x5 Keccak states with valid/ready on both sides.
// Optional fall-through path when empty: define SHA3_STATE_FIFO_BYPASS_EN.
module sha3_state_fifo #(
  parameter int LANE_W = 64,
  parameter int DEPTH  = 2
) (
  input logic              clk,
  input logic              rst,
  sha3_state_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane
    $error("sha3_state_fifo: LANE_W must be 8, 16, 32 or 64");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("sha3_state_fifo: DEPTH must be in 1..16");
  end

  typedef logic [4:0][4:0][LANE_W-1:0] state_t;

  state_t           mem [DEPTH];
  state_t           last;
  state_t           in_state;
  state_t           head;
  state_t           out_state;
  logic [PTR_W-1:0] wp, rp;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             ff_valid, bypass, ovalid, iready;
  logic             push, pop, pass, wr, rd;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_state = {bus.ise, bus.isd, bus.isc, bus.isb, bus.isa};
  assign head     = mem[rp];
  assign ff_valid = (cnt != '0);

`ifdef SHA3_STATE_FIFO_BYPASS_EN
  assign bypass = (cnt == '0) && bus.ivalid;
`else
  assign bypass = 1'b0;
`endif

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // iready depends combinationally on oready (pop frees a slot when full) but
  // never on ivalid.
  assign iready = (cnt < CNT_W'(DEPTH)) || bus.oready;
  assign ovalid = ff_valid || bypass;
  assign push   = bus.ivalid && iready;
  assign pop    = ovalid && bus.oready;
  assign pass   = bypass && bus.oready;
  assign wr     = push && !pass;
  assign rd     = pop && !pass;

  // When nothing is queued the outputs show the most recently departed state.
  assign out_state = ff_valid ? head : (bypass ? in_state : last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      last <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= in_state;
        wp      <= ptr_next(wp);
      end
      if (rd) rp <= ptr_next(rp);
      if (wr && !rd)      cnt <= cnt + CNT_W'(1);
      else if (rd && !wr) cnt <= cnt - CNT_W'(1);
      if (rd)        last <= head;
      else if (pass) last <= in_state;
      if (bus.ivalid && !iready) ovf <= 1'b1;
    end
  end

  assign bus.iready   = iready;
  assign bus.ovalid   = ovalid;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
  assign bus.osa      = out_state[0];
  assign bus.osb      = out_state[1];
  assign bus.osc      = out_state[2];
  assign bus.osd      = out_state[3];
  assign bus.ose      = out_state[4];
endmodule

// File: tb/tb_sha3_state_fifo.sv
// Directed bench for sha3_state_fifo: a DEPTH=2/64-bit instance and a DEPTH=3/32-bit instance.
module tb_sha3_state_fifo;
  typedef logic [4:0][4:0][63:0] st64_t;
  typedef logic [4:0][4:0][31:0] st32_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    n_assert = 0;
  int    n_fail   = 0;
  st64_t s [1:12];
  st32_t exp_q [$];

  sha3_state_fifo_if #(.LANE_W(64), .DEPTH(2)) b2 ();
  sha3_state_fifo_if #(.LANE_W(32), .DEPTH(3)) b3 ();

  sha3_state_fifo #(.LANE_W(64), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  sha3_state_fifo #(.LANE_W(32), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  always #5 clk = ~clk;

  function automatic st64_t mk64(input int c);
    st64_t t;
    for (int r = 0; r < 5; r++)
      for (int l = 0; l < 5; l++) t[r][l] = {8'(r), 8'(l), 48'(c)};
    return t;
  endfunction

  function automatic st32_t mk32(input int c);
    st32_t t;
    for (int r = 0; r < 5; r++)
      for (int l = 0; l < 5; l++) t[r][l] = {4'(r), 4'(l), 24'(c)};
    return t;
  endfunction

  function automatic st64_t o2();
    return {b2.ose, b2.osd, b2.osc, b2.osb, b2.osa};
  endfunction

  function automatic st32_t o3();
    return {b3.ose, b3.osd, b3.osc, b3.osb, b3.osa};
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input st64_t obs, input st64_t exp);
    for (int r = 0; r < 5; r++) chk($sformatf("%s.row%0d", tag, r), obs[r], exp[r]);
  endtask

  task automatic chk32(input string tag, input st32_t obs, input st32_t exp);
    for (int r = 0; r < 5; r++) chk($sformatf("%s.row%0d", tag, r), obs[r], exp[r]);
  endtask

  task automatic drv2(input bit v, input st64_t t, input bit r);
    b2.ivalid = v;
    b2.isa = t[0]; b2.isb = t[1]; b2.isc = t[2]; b2.isd = t[3]; b2.ise = t[4];
    b2.oready = r;
  endtask

  task automatic drv3(input bit v, input st32_t t, input bit r);
    b3.ivalid = v;
    b3.isa = t[0]; b3.isb = t[1]; b3.isc = t[2]; b3.isd = t[3]; b3.ise = t[4];
    b3.oready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           pushed;
    int           cyc;
    bit           v, r, exp_ov, exp_ir;
    logic [15:0]  vpat;
    logic [15:0]  rpat;

    for (int i = 1; i <= 12; i++) s[i] = mk64(i);
    drv2(1'b0, '0, 1'b0);
    drv3(1'b0, '0, 1'b0);

    // ---- reset state ----
    rst = 1'b0;
    tick();
    tick();
    chk("rst.count", b2.count, 0);
    chk("rst.ovalid", b2.ovalid, 0);
    chk("rst.iready", b2.iready, 1);
    chk("rst.overflow", b2.overflow, 0);
    chk64("rst.out", o2(), '0);
    chk("rst.d3count", b3.count, 0);
    rst = 1'b1;
    tick();

    // ---- fill with S1, S2 while consumer stalls ----
    drv2(1'b1, s[1], 1'b0);
    tick();
    drv2(1'b1, s[2], 1'b0);
    tick();
    drv2(1'b0, '0, 1'b0);
    #1;
    chk("fill.count", b2.count, 2);
    chk("fill.iready", b2.iready, 0);
    chk("fill.ovalid", b2.ovalid, 1);
    chk("fill.osa0", b2.osa[0], s[1][0][0]);
    chk64("fill.head", o2(), s[1]);
    drv2(1'b0, '0, 1'b1);
    #1;
    chk("drain.iready_comb", b2.iready, 1);
    chk64("drain.s1", o2(), s[1]);
    tick();
    chk("drain.count1", b2.count, 1);
    chk64("drain.s2", o2(), s[2]);
    tick();
    drv2(1'b0, '0, 1'b0);
    #1;
    chk("drain.count0", b2.count, 0);
    chk("drain.ovalid0", b2.ovalid, 0);
    chk64("drain.hold_last", o2(), s[2]);

    // ---- overflow: push into full FIFO with oready=0 is dropped ----
    drv2(1'b1, s[3], 1'b0);
    tick();
    drv2(1'b1, s[4], 1'b0);
    tick();
    drv2(1'b1, s[5], 1'b0);
    #1;
    chk("ovf.iready", b2.iready, 0);
    tick();
    drv2(1'b0, '0, 1'b0);
    #1;
    chk("ovf.flag", b2.overflow, 1);
    chk("ovf.count", b2.count, 2);
    chk64("ovf.head", o2(), s[3]);
    drv2(1'b0, '0, 1'b1);
    tick();
    chk64("ovf.pop2", o2(), s[4]);
    tick();
    drv2(1'b0, '0, 1'b0);
    #1;
    chk("ovf.count0", b2.count, 0);
    chk("ovf.sticky", b2.overflow, 1);

    // ---- full with simultaneous push and pop ----
    drv2(1'b1, s[6], 1'b0);
    tick();
    drv2(1'b1, s[7], 1'b0);
    tick();
    drv2(1'b1, s[8], 1'b1);
    #1;
    chk("pp.iready", b2.iready, 1);
    chk64("pp.head_before", o2(), s[6]);
    tick();
    drv2(1'b0, '0, 1'b1);
    #1;
    chk("pp.count", b2.count, 2);
    chk64("pp.head_after", o2(), s[7]);
    tick();
    chk("pp.count1", b2.count, 1);
    chk64("pp.tail", o2(), s[8]);
    tick();
    drv2(1'b0, '0, 1'b0);
    #1;
    chk("pp.count0", b2.count, 0);
    chk("pp.sticky", b2.overflow, 1);

    // ---- DEPTH=3, 32-bit lanes: fixed irregular valid/ready pattern vs queue ----
    vpat   = 16'hBE7D;
    rpat   = 16'h275B;
    pushed = 0;
    cyc    = 0;
    while ((pushed < 10 || exp_q.size() != 0) && cyc < 80) begin
      v = vpat[cyc % 16] && (pushed < 10);
      r = rpat[cyc % 16];
      drv3(v, mk32(100 + pushed), r);
      #1;
      exp_ov = (exp_q.size() != 0);
`ifdef SHA3_STATE_FIFO_BYPASS_EN
      if (exp_q.size() == 0 && v) exp_ov = 1'b1;
`endif
      exp_ir = (exp_q.size() < 3) || r;
      chk("d3.count", b3.count, exp_q.size());
      chk("d3.ovalid", b3.ovalid, exp_ov);
      chk("d3.iready", b3.iready, exp_ir);
`ifdef SHA3_STATE_FIFO_BYPASS_EN
      if (exp_q.size() == 0 && v && r) begin
        chk32("d3.pass", o3(), mk32(100 + pushed));
        pushed++;
      end else
`endif
      begin
        if (exp_q.size() != 0 && r) begin
          chk32("d3.head", o3(), exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (v && exp_ir) begin
          exp_q.push_back(mk32(100 + pushed));
          pushed++;
        end
      end
      tick();
      cyc++;
    end
    drv3(1'b0, '0, 1'b0);
    chk("d3.done", {pushed == 10, exp_q.size() == 0}, 2'b11);
    chk("d3.overflow", b3.overflow, 0);

    // ---- reset while full and pushing ----
    drv2(1'b1, s[9], 1'b0);
    tick();
    drv2(1'b1, s[10], 1'b0);
    tick();
    rst = 1'b0;
    drv2(1'b1, s[11], 1'b0);
    tick();
    rst = 1'b1;
    drv2(1'b0, '0, 1'b0);
    #1;
    chk("mrst.count", b2.count, 0);
    chk("mrst.ovalid", b2.ovalid, 0);
    chk("mrst.overflow", b2.overflow, 0);
    chk("mrst.iready", b2.iready, 1);
    chk64("mrst.out", o2(), '0);
    tick();
    chk("mrst.absent", {b2.count, b2.ovalid}, 0);

    // ---- latency into empty FIFO with oready=1 ----
    drv2(1'b1, s[12], 1'b1);
    #1;
`ifdef SHA3_STATE_FIFO_BYPASS_EN
    chk("lat.ovalid0", b2.ovalid, 1);
    chk64("lat.pass", o2(), s[12]);
`else
    chk("lat.ovalid0", b2.ovalid, 0);
`endif
    tick();
    drv2(1'b0, '0, 1'b0);
    #1;
`ifdef SHA3_STATE_FIFO_BYPASS_EN
    chk("lat.count", b2.count, 0);
    chk("lat.ovalid1", b2.ovalid, 0);
`else
    chk("lat.count", b2.count, 1);
    chk("lat.ovalid1", b2.ovalid, 1);
    chk64("lat.head", o2(), s[12]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
